// File: rtl/edge_capture_multi.sv
// Per-bit rising/falling/any-edge capture with an optional input synchroniser.
// Provides sticky W1C capture, single-cycle pulses, a masked interrupt and a saturating event counter.
module edge_capture_multi #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] clear_i,
  input  logic [WIDTH-1:0] irq_mask_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] edge_o,
  output logic [WIDTH-1:0] pulse_o,
  output logic             irq_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam int SUM_W = CNT_W + $clog2(WIDTH) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] data_s;
  logic [WIDTH-1:0] prev_q;
  logic             primed_q;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] pulse_q;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [SUM_W-1:0] pop_cnt, cnt_base, cnt_sum;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_s = data_i;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= data_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign data_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // No detection until prev holds a real sample, so the reset value never looks like an edge.
  assign det = ((data_s & ~prev_q & rise_en_i) | (~data_s & prev_q & fall_en_i))
               & {WIDTH{primed_q}};

  assign edge_d = (edge_q & ~clear_i) | det;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) pop_cnt = pop_cnt + SUM_W'(det[i]);
    cnt_base  = cnt_clr_i ? '0 : SUM_W'(evt_cnt_q);
    cnt_sum   = cnt_base + pop_cnt;
    evt_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      primed_q  <= 1'b0;
      edge_q    <= '0;
      pulse_q   <= '0;
      evt_cnt_q <= '0;
    end else begin
      prev_q    <= data_s;
      primed_q  <= 1'b1;
      edge_q    <= edge_d;
      pulse_q   <= det;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign edge_o    = edge_q;
  assign pulse_o   = pulse_q;
  assign evt_cnt_o = evt_cnt_q;
  assign irq_o     = |(edge_q & irq_mask_i);

endmodule

// File: tb/tb_edge_capture_multi.sv
// Directed bench for edge_capture_multi: default, 2-stage synchronised and 4-bit-counter instances
// share one stimulus stream; each step is checked with immediate assertions.
module tb_edge_capture_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data, rise_en, fall_en, clr, mask;
  logic        cnt_clr;

  logic [31:0] e0, p0, es, ps, ea, pa;
  logic        i0, is_, ia;
  logic [7:0]  c0, cs;
  logic [3:0]  ca;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  edge_capture_multi #(.WIDTH(32), .SYNC_STAGES(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .data_i(data), .rise_en_i(rise_en), .fall_en_i(fall_en),
    .clear_i(clr), .irq_mask_i(mask), .cnt_clr_i(cnt_clr),
    .edge_o(e0), .pulse_o(p0), .irq_o(i0), .evt_cnt_o(c0));

  edge_capture_multi #(.WIDTH(32), .SYNC_STAGES(2), .CNT_W(8)) dut_sync (
    .clk(clk), .reset(reset), .data_i(data), .rise_en_i(rise_en), .fall_en_i(fall_en),
    .clear_i(clr), .irq_mask_i(mask), .cnt_clr_i(cnt_clr),
    .edge_o(es), .pulse_o(ps), .irq_o(is_), .evt_cnt_o(cs));

  edge_capture_multi #(.WIDTH(32), .SYNC_STAGES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .data_i(data), .rise_en_i(rise_en), .fall_en_i(fall_en),
    .clear_i(clr), .irq_mask_i(mask), .cnt_clr_i(cnt_clr),
    .edge_o(ea), .pulse_o(pa), .irq_o(ia), .evt_cnt_o(ca));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t data=%h pulse=%h edge=%h cnt=%0d irq=%b | sync pulse=%h | sat cnt=%0d",
             $time, data, p0, e0, c0, i0, ps, ca);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data = '0; rise_en = '0; fall_en = '1; clr = '0; mask = 32'h10; cnt_clr = 1'b0;

    // Falling-edge sequence, irq on bit 4, and the synchronised instance alongside
    do_reset();
    chk("rst_edge", e0, 32'h0); chk("rst_pulse", p0, 32'h0);
    chk("rst_cnt", 32'(c0), 32'd0); chk("rst_irq", 32'(i0), 32'd0);
    tick();
    chk("s1_prime_pulse", p0, 32'h0); chk("s1_sync_t0", ps, 32'h0);
    data = 32'hA6; tick();
    chk("s1_a6_pulse", p0, 32'h0); chk("s1_sync_t1", ps, 32'h0);
    data = 32'hBC; tick();
    chk("s1_bc_pulse", p0, 32'h02); chk("s1_bc_edge", e0, 32'h02);
    chk("s1_bc_cnt", 32'(c0), 32'd1); chk("s1_sync_t2", ps, 32'h0);
    data = 32'hBA; tick();
    chk("s1_ba_pulse", p0, 32'h04); chk("s1_ba_edge", e0, 32'h06);
    chk("s1_ba_cnt", 32'(c0), 32'd2); chk("s1_ba_irq", 32'(i0), 32'd0);
    chk("s1_sync_t3", ps, 32'h0);
    data = 32'hEB; tick();
    chk("s1_eb_pulse", p0, 32'h10); chk("s1_eb_edge", e0, 32'h16);
    chk("s1_eb_cnt", 32'(c0), 32'd3); chk("s6_irq_rise", 32'(i0), 32'd1);
    chk("s6_sync_t4", ps, 32'h02);
    tick();
    chk("s1_hold_pulse", p0, 32'h0); chk("s1_hold_edge", e0, 32'h16);
    chk("s6_sync_t5", ps, 32'h04);
    tick();
    chk("s6_sync_t6", ps, 32'h10); chk("s6_sync_edge", es, 32'h16);
    chk("s6_sync_cnt", 32'(cs), 32'd3);

    // Asynchronous reset mid-cycle
    #3 reset = 1'b0;
    #1;
    chk("s6_async_edge", e0, 32'h0); chk("s6_async_irq", 32'(i0), 32'd0);
    chk("s6_async_cnt", 32'(c0), 32'd0); chk("s6_async_sync_edge", es, 32'h0);

    // Rising-edge sequence
    data = '0; rise_en = '1; fall_en = '0;
    do_reset();
    tick();
    data = 32'hA6; tick();
    chk("s2_a6_pulse", p0, 32'hA6); chk("s2_a6_cnt", 32'(c0), 32'd4);
    data = 32'hBC; tick();
    chk("s2_bc_pulse", p0, 32'h18);
    data = 32'hBA; tick();
    chk("s2_ba_pulse", p0, 32'h02);
    data = 32'hEB; tick();
    chk("s2_eb_pulse", p0, 32'h41); chk("s2_edge", e0, 32'hFF);
    chk("s2_cnt", 32'(c0), 32'd9);

    // Primed flag: reset released with all inputs high
    data = '1; rise_en = '1; fall_en = '1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_edge", e0, 32'h0); chk("s3_cnt", 32'(c0), 32'd0);
    end

    // Set wins over clear
    data = '0; rise_en = '0; fall_en = '1;
    do_reset();
    tick();
    data = 32'hA6; tick();
    data = 32'hBC; tick();
    data = 32'hBA; tick();
    chk("s4_pre_edge", e0, 32'h06);
    data = 32'hB8; clr = 32'h06; tick();
    chk("s4_setwins_edge", e0, 32'h02); chk("s4_setwins_pulse", p0, 32'h02);
    clr = 32'h02; tick();
    chk("s4_clear_edge", e0, 32'h0);
    clr = '0;

    // Counter saturation (4-bit instance) and unsaturated reference (8-bit)
    data = '0; rise_en = '1; fall_en = '1;
    do_reset();
    tick();
    data = '1; tick();
    chk("s5_sat_first", 32'(ca), 32'd15); chk("s5_ref_first", 32'(c0), 32'd32);
    data = '0; tick();
    chk("s5_sat_hold1", 32'(ca), 32'd15); chk("s5_ref_second", 32'(c0), 32'd64);
    data = '1; tick();
    chk("s5_sat_hold2", 32'(ca), 32'd15);
    data = '0; cnt_clr = 1'b1; tick();
    chk("s5_sat_clr_toggle", 32'(ca), 32'd15); chk("s5_ref_clr_toggle", 32'(c0), 32'd32);
    tick();
    chk("s5_sat_clr_only", 32'(ca), 32'd0); chk("s5_ref_clr_only", 32'(c0), 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("s5_sat_idle", 32'(ca), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
